free_list: RTL and testbench

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list_if.sv | 28 ++
 rtl/free_list.sv | 60 ++++++
 tb/tb_free_list.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/free_list_if.sv
// free_list_if: rename/commit/branch handshake bundle for the physical register free list
interface free_list_if #(
  parameter int NUM_PREGS = 128,
  parameter int NUM_CKPT  = 4
);
  localparam int PW = $clog2(NUM_PREGS);
  localparam int TW = $clog2(NUM_CKPT);
  logic          alloc_req;
  logic          alloc_grant;
  logic [PW-1:0] pd_new;
  logic          empty;
  logic [PW:0]   free_count;
  logic          free_en;
  logic [PW-1:0] free_pd;
  logic          branch;
  logic [TW-1:0] branch_tag;
  logic          mispredict;
  logic [TW-1:0] mispredict_tag;
  logic          overflow_err;
  modport master (
    output alloc_req, free_en, free_pd, branch, branch_tag, mispredict, mispredict_tag,
    input  alloc_grant, pd_new, empty, free_count, overflow_err
  );
  modport slave (
    input  alloc_req, free_en, free_pd, branch, branch_tag, mispredict, mispredict_tag,
    output alloc_grant, pd_new, empty, free_count, overflow_err
  );
endinterface

// File: rtl/free_list.sv
// free_list: circular free list of physical registers with branch checkpoints of the head
module free_list #(
  parameter int NUM_PREGS = 128,
  parameter int NUM_AREGS = 32,
  parameter int NUM_CKPT  = 4
) (
  input logic       clk,
  input logic       reset,
  free_list_if.slave fl
);
  localparam int PW = $clog2(NUM_PREGS);
  logic [PW-1:0] r_mem [NUM_PREGS];
  logic [PW:0]   r_head;
  logic [PW:0]   r_tail;
  logic [PW:0]   r_ckpt [NUM_CKPT];
  logic          r_ovf;
  logic [PW:0]   w_count;
  logic          w_full;
  logic          w_grant;
  logic          w_push;
  assign w_count        = r_tail - r_head;
  assign w_full         = w_count == (PW+1)'(NUM_PREGS);
  assign w_grant        = fl.alloc_req & ~fl.empty & ~fl.branch & ~fl.mispredict;
  assign w_push         = fl.free_en & ~w_full;
  assign fl.empty       = w_count == '0;
  assign fl.free_count  = w_count;
  assign fl.alloc_grant = w_grant;
  assign fl.pd_new      = r_mem[r_head[PW-1:0]];
  assign fl.overflow_err = r_ovf;
  // storage: registers beyond the architectural ones start free; committed frees land at the tail
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PREGS; i++)
        r_mem[i] <= (i < NUM_PREGS - NUM_AREGS) ? PW'(i + NUM_AREGS) : '0;
    end else if (w_push) begin
      r_mem[r_tail[PW-1:0]] <= fl.free_pd;
    end
  end
  // pointers: mispredict restore wins over allocation; frees always proceed unless the list is full
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head <= '0;
      r_tail <= (PW+1)'(NUM_PREGS - NUM_AREGS);
      r_ovf  <= 1'b0;
    end else begin
      r_head <= fl.mispredict ? r_ckpt[fl.mispredict_tag] : r_head + (PW+1)'(w_grant);
      r_tail <= r_tail + (PW+1)'(w_push);
      r_ovf  <= r_ovf | (fl.free_en & w_full);
    end
  end
  // checkpoints: capture the pre-edge head on a branch that is not being squashed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CKPT; i++)
        r_ckpt[i] <= '0;
    end else if (fl.branch && !fl.mispredict) begin
      r_ckpt[fl.branch_tag] <= r_head;
    end
  end
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed and random checks of free_list against a pointer/array reference model
module tb_free_list;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int m_arr [128];
  int m_head, m_tail;
  int m_ck [4];
  bit m_ovf;
  free_list_if #(.NUM_PREGS(128), .NUM_CKPT(4)) fl ();
  free_list #(.NUM_PREGS(128), .NUM_AREGS(32), .NUM_CKPT(4)) dut (.clk(clk), .reset(reset), .fl(fl));
  always #5 clk = ~clk;
  function automatic int m_cnt();
    return (m_tail - m_head) & 255;
  endfunction
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    for (int i = 0; i < 128; i++) m_arr[i] = (i < 96) ? i + 32 : 0;
    m_head = 0;
    m_tail = 96;
    for (int i = 0; i < 4; i++) m_ck[i] = 0;
    m_ovf = 0;
  endtask
  task automatic chk_model(input string tag);
    chk({tag, ".count"}, int'(fl.free_count), m_cnt());
    chk({tag, ".empty"}, int'(fl.empty), int'(m_cnt() == 0));
    chk({tag, ".pd_new"}, int'(fl.pd_new), m_arr[m_head & 127]);
    chk({tag, ".ovf"}, int'(fl.overflow_err), int'(m_ovf));
  endtask
  task automatic cyc(input bit req, input bit fe, input int pd, input bit br, input int bt,
                     input bit mp, input int mt);
    bit g;
    bit push;
    fl.alloc_req = req; fl.free_en = fe; fl.free_pd = 7'(pd);
    fl.branch = br; fl.branch_tag = 2'(bt); fl.mispredict = mp; fl.mispredict_tag = 2'(mt);
    #1;
    g = req && m_cnt() != 0 && !br && !mp;
    chk_model("cyc");
    chk("cyc.grant", int'(fl.alloc_grant), int'(g));
    @(posedge clk);
    push = fe && m_cnt() != 128;
    if (fe && !push) m_ovf = 1;
    if (push) begin
      m_arr[m_tail & 127] = pd & 127;
      m_tail = (m_tail + 1) & 255;
    end
    if (mp) m_head = m_ck[mt];
    else begin
      if (br) m_ck[bt] = m_head;
      if (g) m_head = (m_head + 1) & 255;
    end
    @(negedge clk);
    fl.alloc_req = 0; fl.free_en = 0; fl.branch = 0; fl.mispredict = 0;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    #1;
    m_reset();
    chk("rst.count", int'(fl.free_count), 96);
    chk("rst.pd_new", int'(fl.pd_new), 32);
    chk("rst.empty", int'(fl.empty), 0);
    chk("rst.ovf", int'(fl.overflow_err), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    int h1;
    fl.alloc_req = 0; fl.free_en = 0; fl.free_pd = 0;
    fl.branch = 0; fl.branch_tag = 0; fl.mispredict = 0; fl.mispredict_tag = 0;
    @(negedge clk);
    do_reset();
    // three allocations from reset
    for (int i = 0; i < 3; i++) begin
      #1 chk("seq.pd_new", int'(fl.pd_new), 32 + i);
      cyc(1, 0, 0, 0, 0, 0, 0);
    end
    #1 chk("seq.count", int'(fl.free_count), 93);
    // drain to empty, then free into an empty list
    do_reset();
    for (int i = 0; i < 96; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    #1 chk("drain.empty", int'(fl.empty), 1);
    chk("drain.grant", int'(fl.alloc_grant), 0);
    cyc(1, 1, 5, 0, 0, 0, 0);
    #1 chk("refill.pd_new", int'(fl.pd_new), 5);
    chk("refill.count", int'(fl.free_count), 1);
    // checkpoint and restore
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 2, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 2);
    #1 chk("restore.pd_new", int'(fl.pd_new), 36);
    chk("restore.count", int'(fl.free_count), 92);
    // simultaneous alloc and free at count 50
    do_reset();
    for (int i = 0; i < 46; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    #1 chk("both.count0", int'(fl.free_count), 50);
    fl.alloc_req = 1;
    #1 chk("both.grant", int'(fl.alloc_grant), 1);
    cyc(1, 1, 7, 0, 0, 0, 0);
    #1 chk("both.count1", int'(fl.free_count), 50);
    // mispredict with branch, alloc and free all in the same cycle
    cyc(0, 0, 0, 1, 1, 0, 0);
    h1 = m_head;
    cyc(0, 0, 0, 1, 3, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 9, 1, 1, 1, 3);
    #1 chk("mp.pd_new", int'(fl.pd_new), m_arr[h1 & 127]);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    #1 chk("mp.ckpt_kept", int'(fl.pd_new), m_arr[h1 & 127]);
    // asynchronous reset between edges, then overflow
    cyc(1, 1, 11, 0, 0, 0, 0);
    #2 do_reset();
    for (int i = 0; i < 32; i++) cyc(0, 1, i + 64, 0, 0, 0, 0);
    #1 chk("full.count", int'(fl.free_count), 128);
    chk("full.ovf0", int'(fl.overflow_err), 0);
    cyc(0, 1, 99, 0, 0, 0, 0);
    #1 chk("ovf.set", int'(fl.overflow_err), 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    #1 chk("ovf.sticky", int'(fl.overflow_err), 1);
    // random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, $urandom_range(0, 127),
          $urandom_range(0, 19) < 3, $urandom_range(0, 3),
          $urandom_range(0, 19) < 2, $urandom_range(0, 3));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
